serial_deframer: RTL and testbench

//  Receive-side stage fed by the c4 serial output (sdo). Detects start bit, shifts in
//  W data bits LSB-first, checks optional parity and stop bit, presents parallel word

---
 rtl/serial_deframer.sv | 148 ++++++++++++++
 tb/tb_serial_deframer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/serial_deframer.sv
// Serial deframer: start bit, W data bits LSB-first, optional parity, stop bit -> parallel word with valid/ready.
// Registers update on the falling edge of n_clk; optional parity bit enabled by SERIAL_DEFRAMER_PARITY_EN.
module serial_deframer #(
    parameter int W       = 8,
    parameter bit PAR_ODD = 1'b0
) (
    input  logic         n_clk,
    input  logic         rst,
    input  logic         sdi,
    input  logic         en,
    input  logic         rdy,
    output logic [W-1:0] dout,
    output logic         dvalid,
    output logic         busy,
    output logic         ferr,
    output logic         perr,
    output logic         ovr
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_PAR   = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [W-1:0]  r_shift;
    logic [W-1:0]  r_dout;
    logic          r_dvalid;
    logic          r_ferr;
    logic          r_perr;
    logic          r_ovr;

    logic w_last;
    logic w_stop_edge;
    logic w_done;
    logic w_ferr;
    logic w_par_bad;
    logic w_good;
    logic w_load;
    logic w_ovr;
    logic w_accept;

    assign w_last = (r_cnt == CW'(W - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (en) begin
            case (r_state)
                S_IDLE: begin
                    if (!sdi) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    if (w_last) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
                        w_state_nxt = S_PAR;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_PAR:   w_state_nxt = S_STOP;
                S_STOP:  w_state_nxt = sdi ? S_IDLE : S_BREAK;
                S_BREAK: begin
                    // Line held low: wait for mark before looking for a new start bit
                    if (sdi) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    assign w_stop_edge = en & (r_state == S_STOP);
    assign w_done      = w_stop_edge & sdi;
    assign w_ferr      = w_stop_edge & ~sdi;

`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic r_par_bit;

    always_ff @(negedge n_clk or posedge rst) begin
        if (rst) begin
            r_par_bit <= 1'b0;
        end else if (en && (r_state == S_PAR)) begin
            r_par_bit <= sdi;
        end
    end

    assign w_par_bad = w_done & ((^r_shift ^ PAR_ODD) != r_par_bit);
`else
    // No parity bit in the frame; PAR_ODD has no effect in this build
    assign w_par_bad = 1'b0 & PAR_ODD;
`endif

    assign w_good   = w_done & ~w_par_bad;
    assign w_load   = w_good & (~r_dvalid | rdy);
    assign w_ovr    = w_good & r_dvalid & ~rdy;
    assign w_accept = r_dvalid & rdy;

    always_ff @(negedge n_clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
            r_ovr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (en && (r_state == S_DATA)) begin
                r_shift <= {sdi, r_shift[W-1:1]};
            end
            // Pulses are rewritten every edge so they never outlast one cycle
            r_ferr <= w_ferr;
            r_perr <= w_par_bad;
            r_ovr  <= w_ovr;
            if (w_load) begin
                r_dout   <= r_shift;
                r_dvalid <= 1'b1;
            end else if (w_accept) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    assign dout   = r_dout;
    assign dvalid = r_dvalid;
    assign busy   = (r_state != S_IDLE);
    assign ferr   = r_ferr;
    assign perr   = r_perr;
    assign ovr    = r_ovr;

endmodule

// File: tb/tb_serial_deframer.sv
// Directed bench for serial_deframer (W=8, even parity); inputs change 1 time unit after each falling edge.
module tb_serial_deframer;

    localparam int W       = 8;
    localparam bit PAR_ODD = 1'b0;

    logic         n_clk = 1'b1;
    logic         rst   = 1'b1;
    logic         sdi   = 1'b1;
    logic         en    = 1'b1;
    logic         rdy   = 1'b0;
    logic [W-1:0] dout;
    logic         dvalid;
    logic         busy;
    logic         ferr;
    logic         perr;
    logic         ovr;

    int n_vec = 0;
    int n_err = 0;

    serial_deframer #(.W(W), .PAR_ODD(PAR_ODD)) dut (
        .n_clk  (n_clk),
        .rst    (rst),
        .sdi    (sdi),
        .en     (en),
        .rdy    (rdy),
        .dout   (dout),
        .dvalid (dvalid),
        .busy   (busy),
        .ferr   (ferr),
        .perr   (perr),
        .ovr    (ovr)
    );

    always #5 n_clk = ~n_clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    typedef struct packed {
        logic [7:0] data;
        logic       bad_par;
        logic       tog;
        logic       rdy_stop;
        logic       pre_dv;
        logic       exp_dv;
        logic [7:0] exp_dout;
        logic       exp_ovr;
        logic       exp_perr;
        logic       ack;
        logic       idle;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_in(input logic s, input logic e, input logic r);
        sdi = s;
        en  = e;
        rdy = r;
        @(negedge n_clk);
        #1;
    endtask

    // Drives one frame; returns just after the stop-bit edge
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_p,
                              input logic tog, input logic rdy_s, input logic pre_dv);
        logic b[0:11];
        int   n;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        n = 9;
`ifdef SERIAL_DEFRAMER_PARITY_EN
        b[n] = ^d ^ PAR_ODD ^ bad_p;
        n++;
`endif
        b[n] = stop_b;
        n++;
        for (int k = 0; k < n; k++) begin
            if (tog) edge_in(b[k], 1'b0, 1'b0);
            if (k == n - 1) chk("dvalid_before_stop", 16'(dvalid), 16'(pre_dv));
            edge_in(b[k], 1'b1, (k == n - 1) ? rdy_s : 1'b0);
            if (k == 0) chk("busy_after_start", 16'(busy), 16'd1);
        end
    endtask

    initial begin
        // data bad tog rdyS preDv expDv expDout ovr perr ack idle
        vecs.push_back('{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b1, 1'b1});
        vecs.push_back('{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1});
`ifdef SERIAL_DEFRAMER_PARITY_EN
        vecs.push_back('{8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b1});
`endif

        // Reset and idle line
        #2;
        chk("rst_dvalid", 16'(dvalid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) edge_in(1'b1, 1'b1, 1'b0);
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_dvalid", 16'(dvalid), 16'd0);
        chk("idle_dout", 16'(dout), 16'h0000);
        chk("idle_pulses", {13'd0, ferr, perr, ovr}, 16'd0);

        for (int v = 0; v < vecs.size(); v++) begin
            send_frame(vecs[v].data, 1'b1, vecs[v].bad_par, vecs[v].tog,
                       vecs[v].rdy_stop, vecs[v].pre_dv);
            chk($sformatf("v%0d_dvalid", v), 16'(dvalid), 16'(vecs[v].exp_dv));
            chk($sformatf("v%0d_dout", v), 16'(dout), 16'(vecs[v].exp_dout));
            chk($sformatf("v%0d_ovr", v), 16'(ovr), 16'(vecs[v].exp_ovr));
            chk($sformatf("v%0d_perr", v), 16'(perr), 16'(vecs[v].exp_perr));
            chk($sformatf("v%0d_ferr", v), 16'(ferr), 16'd0);
            if (vecs[v].idle) begin
                edge_in(1'b1, 1'b1, 1'b0);
                chk($sformatf("v%0d_pulse_clear", v), {13'd0, ferr, perr, ovr}, 16'd0);
                chk($sformatf("v%0d_dvalid_held", v), 16'(dvalid), 16'(vecs[v].exp_dv));
                chk($sformatf("v%0d_dout_held", v), 16'(dout), 16'(vecs[v].exp_dout));
                chk($sformatf("v%0d_busy_idle", v), 16'(busy), 16'd0);
            end
            if (vecs[v].ack) begin
                edge_in(1'b1, 1'b1, 1'b1);
                chk($sformatf("v%0d_ack_clear", v), 16'(dvalid), 16'd0);
                chk($sformatf("v%0d_ack_dout", v), 16'(dout), 16'(vecs[v].exp_dout));
            end
        end

        // Framing error, line held low, then recovery
        send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("brk_ferr", 16'(ferr), 16'd1);
        chk("brk_busy", 16'(busy), 16'd1);
        chk("brk_dvalid", 16'(dvalid), 16'd0);
        for (int i = 0; i < 2; i++) begin
            edge_in(1'b0, 1'b1, 1'b0);
            chk("brk_hold_busy", 16'(busy), 16'd1);
            chk("brk_ferr_clear", 16'(ferr), 16'd0);
        end
        edge_in(1'b1, 1'b1, 1'b0);
        chk("brk_exit_busy", 16'(busy), 16'd0);
        send_frame(8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("after_brk_dvalid", 16'(dvalid), 16'd1);
        chk("after_brk_dout", 16'(dout), 16'h0034);
        chk("after_brk_ferr", 16'(ferr), 16'd0);
        edge_in(1'b1, 1'b1, 1'b1);
        chk("after_brk_ack", 16'(dvalid), 16'd0);

        // Asynchronous reset in the middle of a data field
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_dvalid", 16'(dvalid), 16'd1);
        edge_in(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) edge_in(1'b1, 1'b1, 1'b0);
        chk("mid_busy", 16'(busy), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 16'(busy), 16'd0);
        chk("mid_rst_dvalid", 16'(dvalid), 16'd0);
        chk("mid_rst_dout", 16'(dout), 16'h0000);
        #1 rst = 1'b0;
        edge_in(1'b1, 1'b1, 1'b0);
        chk("post_rst_pulses", {13'd0, ferr, perr, ovr}, 16'd0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_dvalid", 16'(dvalid), 16'd1);
        chk("post_rst_dout", 16'(dout), 16'h0022);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
